// File: rtl/pipelined_mem_lane.sv
// SIMT processing lane: register file, ALU with multi-cycle MUL and a LOAD/STORE
// port. Executes one instruction at a time and reports retirement with a done pulse.
module pipelined_mem_lane #(
  parameter int LANE_ID     = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [31:0]           instruction,
  input  logic                  lane_enable,
  output logic                  done,
  output logic                  done_skipped,
  output logic                  done_illegal,
  output logic                  done_overflow,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [7:0]            lane_id_o
);

  localparam int RA_W  = $clog2(NUM_REGS);
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int MSB   = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD   = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,
    OP_AND  = 4'd4,  OP_OR    = 4'd5,  OP_XOR  = 4'd6,  OP_ADDI = 4'd7,
    OP_LOAD = 4'd8,  OP_STORE = 4'd9,  OP_SLT  = 4'd10, OP_SHL  = 4'd11,
    OP_MOVI = 4'd12
  } op_t;

  state_t                state_q, state_d;
  logic [31:0]           inst_q;
  logic                  skip_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, res_q;
  logic                  ovf_q;
  logic [CNT_W-1:0]      mul_cnt_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_we_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  op_t                   op;
  logic [RA_W-1:0]       dst, src1, src2;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  illegal, is_mem, writes_rd, mul_last, wb_en;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ovf;

  assign op        = op_t'(inst_q[31:28]);
  assign dst       = inst_q[23 +: RA_W];
  assign src1      = inst_q[18 +: RA_W];
  assign src2      = inst_q[13 +: RA_W];
  assign imm_ext   = {{(DATA_WIDTH-13){inst_q[12]}}, inst_q[12:0]};
  assign illegal   = inst_q[31:28] > 4'd12;
  assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
  assign writes_rd = !illegal && (op != OP_NOP) && (op != OP_STORE);
  assign mul_last  = (mul_cnt_q == CNT_W'(MUL_LATENCY - 1));
  // r0 is never written, so it keeps its reset value of zero.
  assign wb_en     = (state_q == S_WB) && !skip_q && writes_rd && (dst != '0);

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = op_a_q + op_b_q;
        alu_ovf = (op_a_q[MSB] == op_b_q[MSB]) && (alu_res[MSB] != op_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = op_a_q - op_b_q;
        alu_ovf = (op_a_q[MSB] != op_b_q[MSB]) && (alu_res[MSB] != op_a_q[MSB]);
      end
      OP_ADDI: begin
        alu_res = op_a_q + imm_ext;
        alu_ovf = (op_a_q[MSB] == imm_ext[MSB]) && (alu_res[MSB] != op_a_q[MSB]);
      end
      OP_MUL:  alu_res = op_a_q * op_b_q;
      OP_AND:  alu_res = op_a_q & op_b_q;
      OP_OR:   alu_res = op_a_q | op_b_q;
      OP_XOR:  alu_res = op_a_q ^ op_b_q;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
      OP_SHL:  alu_res = op_a_q << op_b_q[SH_W-1:0];
      OP_MOVI: alu_res = imm_ext;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (inst_valid) state_d = lane_enable ? S_READ : S_WB;
      S_READ:     state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_MUL && !mul_last) state_d = S_EXEC;
        else if (is_mem)               state_d = S_MEM_REQ;
        else                           state_d = S_WB;
      end
      S_MEM_REQ:  if (mem_req_ready) state_d = req_we_q ? S_WB : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_rsp_valid) state_d = S_WB;
      S_WB:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the register file is reset because an abort must leave all registers
  // at zero; this costs a reset on every storage bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      skip_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      mul_cnt_q   <= '0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (inst_valid) begin
          inst_q <= instruction;
          skip_q <= ~lane_enable;
          ovf_q  <= 1'b0;
        end
        S_READ: begin
          op_a_q    <= rf[src1];
          op_b_q    <= rf[src2];
          mul_cnt_q <= '0;
        end
        S_EXEC: begin
          mul_cnt_q   <= mul_cnt_q + 1'b1;
          res_q       <= alu_res;
          ovf_q       <= alu_ovf;
          req_addr_q  <= ADDR_WIDTH'(op_a_q + imm_ext);
          req_we_q    <= (op == OP_STORE);
          req_wdata_q <= op_b_q;
        end
        S_MEM_WAIT: if (mem_rsp_valid) res_q <= mem_rsp_rdata;
        S_WB:       if (wb_en) rf[dst] <= res_q;
        default: ;
      endcase
    end
  end

  assign inst_ready    = (state_q == S_IDLE);
  assign done          = (state_q == S_WB);
  assign done_skipped  = done && skip_q;
  assign done_illegal  = done && !skip_q && illegal;
  assign done_overflow = done && ovf_q;
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign dbg_data      = rf[dbg_addr[RA_W-1:0]];
  assign lane_id_o     = 8'(LANE_ID);

endmodule

// File: tb/tb_pipelined_mem_lane.sv
// Self-checking bench for pipelined_mem_lane: directed scenarios plus random
// instruction streams compared against an architectural register model.
module tb_pipelined_mem_lane;

  localparam int ML = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] instruction = '0;
  logic        lane_enable = 1'b0;
  logic        done, done_skipped, done_illegal, done_overflow;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [7:0]  lane_id_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rf [32];

  pipelined_mem_lane #(
    .LANE_ID(0), .DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(16), .MUL_LATENCY(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .lane_enable(lane_enable),
    .done(done), .done_skipped(done_skipped), .done_illegal(done_illegal),
    .done_overflow(done_overflow),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .lane_id_o(lane_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s1,
                                      input int s2, input int imm);
    logic [31:0] r;
    r = {op[3:0], d[4:0], s1[4:0], s2[4:0], imm[12:0]};
    return r;
  endfunction

  // Issues one instruction, plays the memory side, and checks timing, flags and
  // the destination register against the architectural model.
  task automatic run_inst(input logic [31:0] ins, input bit en, input int req_delay,
                          input int rsp_delay, input logic [31:0] rsp_data);
    int op, d, s1, s2, exp_k, hs, rc, waited, done_k;
    logic [31:0] a, b, immx, res, sum;
    logic [15:0] addr;
    longint wide;
    bit wr, ovf, is_mem, is_st, seen;
    op = int'(ins[31:28]); d = int'(ins[27:23]); s1 = int'(ins[22:18]); s2 = int'(ins[17:13]);
    a = m_rf[s1]; b = m_rf[s2];
    immx = {{19{ins[12]}}, ins[12:0]};
    sum = a + immx;
    addr = sum[15:0];
    res = '0; wr = 1'b0; ovf = 1'b0;
    is_mem = en && (op == 8 || op == 9);
    is_st  = (op == 9);
    if (en) begin
      case (op)
        1: begin res = a + b; wide = longint'($signed(a)) + longint'($signed(b));
                 ovf = (wide != longint'($signed(res))); wr = 1'b1; end
        2: begin res = a - b; wide = longint'($signed(a)) - longint'($signed(b));
                 ovf = (wide != longint'($signed(res))); wr = 1'b1; end
        3: begin res = a * b; wr = 1'b1; end
        4: begin res = a & b; wr = 1'b1; end
        5: begin res = a | b; wr = 1'b1; end
        6: begin res = a ^ b; wr = 1'b1; end
        7: begin res = a + immx; wide = longint'($signed(a)) + longint'($signed(immx));
                 ovf = (wide != longint'($signed(res))); wr = 1'b1; end
        8: begin res = rsp_data; wr = 1'b1; end
        10: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; end
        11: begin res = a << b[4:0]; wr = 1'b1; end
        12: begin res = immx; wr = 1'b1; end
        default: ;
      endcase
    end
    if (d == 0) wr = 1'b0;
    exp_k = !en ? 1 : ((op == 3) ? 2 + ML : 3);

    @(negedge clk);
    check("ready_idle", inst_ready, 1);
    inst_valid = 1'b1; instruction = ins; lane_enable = en;
    @(posedge clk);
    #1;
    inst_valid = 1'b0; instruction = $urandom; lane_enable = 1'($urandom);

    hs = -1; rc = -1; waited = 0; done_k = -1; seen = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (done) begin done_k = k; break; end
      if (mem_req_valid) begin
        if (!is_mem) check("unexpected_req", 1, 0);
        else begin
          if (!seen) begin check("req_lat", k, 3); seen = 1'b1; end
          check("req_addr", mem_req_addr, addr);
          check("req_we", mem_req_we, is_st);
          if (is_st) check("req_wdata", mem_req_wdata, b);
          if (waited >= req_delay) begin mem_req_ready = 1'b1; hs = k; end
          waited++;
        end
      end
      if (is_mem && !is_st && k == 2) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ~rsp_data;
      end
      if (is_mem && !is_st && hs >= 0 && k == hs + 1 + rsp_delay) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp_data; rc = k;
      end
    end
    if (done_k < 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (is_mem) exp_k = is_st ? hs + 1 : rc + 1;
    check("done_lat", done_k, exp_k);
    check("done_skipped", done_skipped, !en);
    if (en) check("done_illegal", done_illegal, op >= 13);
    check("done_overflow", done_overflow, ovf);
    if (wr) m_rf[d] = res;

    @(negedge clk);
    check("done_pulse", done, 0);
    check("ready_after", inst_ready, 1);
    dbg_addr = d[4:0];
    #1;
    check("dbg_reg", dbg_data, m_rf[d]);
  endtask

  // Starts a LOAD and resets the lane while it waits for the request handshake
  // or for the load response.
  task automatic mid_reset(input bit in_wait);
    bit got;
    @(negedge clk);
    inst_valid = 1'b1; instruction = enc(8, 7, 0, 0, 'h20); lane_enable = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_valid) begin got = 1'b1; break; end
    end
    check("abort_req_seen", got, 1);
    if (in_wait) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_valid", mem_req_valid, 0);
    check("abort_done", {done, done_skipped, done_illegal, done_overflow}, 0);
    check("abort_ready", inst_ready, 1);
    check("abort_req_bus", {mem_req_we, mem_req_addr, mem_req_wdata}, 0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", inst_ready, 1);
      mem_rsp_valid = 1'b0;
    end
    foreach (m_rf[i]) m_rf[i] = '0;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0];
      #1 check("abort_rf_clear", dbg_data, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int op, d, s1, s2, imm;
    bit en;
    foreach (m_rf[i]) m_rf[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", inst_ready, 1);
    check("rst_done", {done, done_skipped, done_illegal, done_overflow}, 0);
    check("rst_req", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, 0);
    check("rst_dbg", dbg_data, 0);
    check("lane_id", lane_id_o, 0);
    rst_n = 1'b1;

    run_inst(enc(12, 1, 0, 0, 5), 1, 0, 0, 0);
    run_inst(enc(12, 2, 0, 0, -3), 1, 0, 0, 0);
    run_inst(enc(1, 3, 1, 2, 0), 1, 0, 0, 0);
    dbg_addr = 5'd3;
    #1 check("add_r3", dbg_data, 2);

    run_inst(enc(12, 1, 0, 0, 'hFFF), 1, 0, 0, 0);
    run_inst(enc(12, 7, 0, 0, 3), 1, 0, 0, 0);
    run_inst(enc(11, 1, 1, 7, 0), 1, 0, 0, 0);
    run_inst(enc(7, 1, 1, 0, 7), 1, 0, 0, 0);
    run_inst(enc(12, 2, 0, 0, 16), 1, 0, 0, 0);
    run_inst(enc(11, 1, 1, 2, 0), 1, 0, 0, 0);
    dbg_addr = 5'd1;
    #1 check("shl_r1", dbg_data, 32'h7FFF_0000);
    run_inst(enc(1, 4, 1, 1, 0), 1, 0, 0, 0);
    dbg_addr = 5'd4;
    #1 check("ovf_r4", dbg_data, 32'hFFFE_0000);

    run_inst(enc(12, 1, 0, 0, 6), 1, 0, 0, 0);
    run_inst(enc(12, 2, 0, 0, 7), 1, 0, 0, 0);
    run_inst(enc(3, 5, 1, 2, 0), 1, 0, 0, 0);
    dbg_addr = 5'd5;
    #1 check("mul_r5", dbg_data, 42);

    run_inst(enc(9, 0, 0, 3, 'h10), 1, 4, 0, 0);
    run_inst(enc(8, 6, 0, 0, 'h10), 1, 0, 2, 32'hABCD);
    dbg_addr = 5'd6;
    #1 check("load_r6", dbg_data, 32'hABCD);

    run_inst(enc(1, 3, 1, 2, 0), 0, 0, 0, 0);
    run_inst(enc(14, 5, 1, 2, 0), 1, 0, 0, 0);
    run_inst(enc(12, 0, 0, 0, 5), 1, 0, 0, 0);
    run_inst(enc(8, 0, 0, 0, 'h44), 1, 1, 1, 32'h5555);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) op = 12;
      d  = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s2 = $urandom_range(0, 7);
      imm = $urandom;
      if (op == 8 || op == 9) begin
        if ($urandom_range(0, 1) == 0) s1 = 0;
        imm = $urandom_range(0, 63);
      end
      en = ($urandom_range(0, 9) != 0);
      run_inst(enc(op, d, s1, s2, imm), en, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    mid_reset(1'b0);
    for (int i = 0; i < 6; i++) run_inst(enc(12, i + 1, 0, 0, i + 100), 1, 0, 0, 0);
    mid_reset(1'b1);
    run_inst(enc(12, 1, 0, 0, 9), 1, 0, 0, 0);
    run_inst(enc(1, 2, 1, 1, 0), 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
